// File: rtl/dmem_rr_arbiter.sv
// Two-port round-robin sequencer in front of the shared delayed data memory.
// Each granted request becomes one rd/wr strobe, then waits for mem_ready under a watchdog.
module dmem_rr_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_ack,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_ack,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  grant,
  output logic                  timeout_err
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic                    we_h_q, we_h_d;
  logic [ADDR_WIDTH-1:0]   addr_h_q, addr_h_d;
  logic [DATA_WIDTH-1:0]   wdata_h_q, wdata_h_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0]   p1_rdata_q, p1_rdata_d;
  logic                    p0_ack_q, p0_ack_d;
  logic                    p1_ack_q, p1_ack_d;
  logic                    rd_en_q, rd_en_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    busy_q, busy_d;
  logic                    terr_q, terr_d;

  // Next-state, hold-register and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_h_d       = we_h_q;
    addr_h_d     = addr_h_q;
    wdata_h_d    = wdata_h_q;
    cnt_d        = cnt_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    terr_d       = terr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (p0_req || p1_req) begin
          if (p0_req && p1_req) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = p1_req;
          end
          if (grant_d) begin
            we_h_d    = p1_we;
            addr_h_d  = p1_addr;
            wdata_h_d = p1_wdata;
          end else begin
            we_h_d    = p0_we;
            addr_h_d  = p0_addr;
            wdata_h_d = p0_wdata;
          end
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        // The memory may not have dropped ready yet in the first WAIT cycle.
        if ((cnt_q != CNT_ZERO) && mem_ready) begin
          state_d = S_DONE;
          if (!we_h_q) begin
            if (grant_q) begin
              p1_rdata_d = mem_rd_data;
            end else begin
              p0_rdata_d = mem_rd_data;
            end
          end else begin
            p0_rdata_d = p0_rdata_q;
          end
        end else if (cnt_d == CNT_MAX) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
          if (grant_q) begin
            p1_rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            p0_rdata_d = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        cnt_d        = CNT_ZERO;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    rd_en_d    = (state_d == S_ISSUE) && !we_h_d;
    wr_en_d    = (state_d == S_ISSUE) && we_h_d;
    mem_addr_d = (state_d != S_IDLE) ? addr_h_d : {ADDR_WIDTH{1'b0}};
    p0_ack_d   = (state_d == S_DONE) && !grant_d;
    p1_ack_d   = (state_d == S_DONE) && grant_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_h_q       <= 1'b0;
      addr_h_q     <= {ADDR_WIDTH{1'b0}};
      wdata_h_q    <= {DATA_WIDTH{1'b0}};
      cnt_q        <= CNT_ZERO;
      p0_rdata_q   <= {DATA_WIDTH{1'b0}};
      p1_rdata_q   <= {DATA_WIDTH{1'b0}};
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_h_q       <= we_h_d;
      addr_h_q     <= addr_h_d;
      wdata_h_q    <= wdata_h_d;
      cnt_q        <= cnt_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
    end
  end

  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_address = mem_addr_q;
  assign mem_wr_data = wdata_h_q;
  assign busy        = busy_q;
  assign grant       = grant_q;
  assign timeout_err = terr_q;

endmodule
